// File: rtl/regfile_dump_reader.sv
// Register file debug dump: walks FIRST_REG..LAST_REG and streams each word as bytes.
// Define REGDUMP_CHECKSUM_EN to append an XOR checksum byte after the last word.
module regfile_dump_reader #(
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dump_req,
    output logic [4:0]  dbg_adr,
    input  logic [31:0] dbg_dout,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] FIRST_A = 5'(FIRST_REG);
    localparam logic [4:0] LAST_A  = 5'(LAST_REG);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
`ifdef REGDUMP_CHECKSUM_EN
        S_CSUM,
`endif
        S_FIN
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  adr_q, adr_d;
    logic [31:0] word_q, word_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  txd_q, txd_d;
    logic        txv_q, txv_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
`ifdef REGDUMP_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    logic xfer, last_byte, last_reg;

    assign xfer      = txv_q & tx_ready;
    assign last_byte = (cnt_q == 2'd3);
    assign last_reg  = (adr_q == LAST_A);

    // Byte i of the stream, honouring the configured byte order.
    function automatic logic [7:0] pick(input logic [31:0] w, input logic [1:0] i);
        logic [1:0] s;
        s = MSB_FIRST ? ~i : i;
        return w[{s, 3'b000} +: 8];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            adr_q   <= FIRST_A;
            word_q  <= '0;
            cnt_q   <= '0;
            txd_q   <= '0;
            txv_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            txd_q   <= txd_d;
            txv_q   <= txv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef REGDUMP_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (dump_req) state_d = S_LOAD;
            S_LOAD: state_d = S_SEND;
            S_SEND: begin
                if (xfer && last_byte) begin
`ifdef REGDUMP_CHECKSUM_EN
                    state_d = last_reg ? S_CSUM : S_LOAD;
`else
                    state_d = last_reg ? S_FIN : S_LOAD;
`endif
                end
            end
`ifdef REGDUMP_CHECKSUM_EN
            S_CSUM: if (xfer) state_d = S_FIN;
`endif
            S_FIN:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        adr_d  = adr_q;
        word_d = word_q;
        cnt_d  = cnt_q;
        txd_d  = txd_q;
        txv_d  = txv_q;
        busy_d = busy_q;
        done_d = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
        csum_d = csum_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (dump_req) begin
                    adr_d  = FIRST_A;
                    busy_d = 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
                    csum_d = '0;
`endif
                end
            end
            S_LOAD: begin
                word_d = dbg_dout;
                cnt_d  = 2'd0;
                txd_d  = pick(dbg_dout, 2'd0);
                txv_d  = 1'b1;
            end
            S_SEND: begin
                if (xfer) begin
`ifdef REGDUMP_CHECKSUM_EN
                    csum_d = csum_q ^ txd_q;
`endif
                    if (!last_byte) begin
                        cnt_d = cnt_q + 2'd1;
                        txd_d = pick(word_q, cnt_q + 2'd1);
                    end else begin
                        txv_d = 1'b0;
                        if (!last_reg) adr_d = adr_q + 5'd1;
                    end
                end
            end
`ifdef REGDUMP_CHECKSUM_EN
            S_CSUM: begin
                if (!txv_q) begin
                    txd_d = csum_q;
                    txv_d = 1'b1;
                end else if (tx_ready) begin
                    txv_d = 1'b0;
                end
            end
`endif
            S_FIN: begin
                done_d = 1'b1;
                busy_d = 1'b0;
                adr_d  = FIRST_A;
            end
            default: ;
        endcase
    end

    assign dbg_adr  = adr_q;
    assign tx_data  = txd_q;
    assign tx_valid = txv_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: three instances (full LSB-first, 4..6 MSB-first, single x7)
// checked against a queue-based stream model of the regfile contents.
module tb_regfile_dump_reader;

`ifdef REGDUMP_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        dump_req [3];
    logic        tx_ready [3];
    logic [4:0]  dbg_adr  [3];
    logic [31:0] dbg_dout [3];
    logic [7:0]  tx_data  [3];
    logic        tx_valid [3];
    logic        busy     [3];
    logic        done     [3];
    logic [31:0] rf [32];

    always #5 clk = ~clk;

    assign dbg_dout[0] = (dbg_adr[0] == 5'd0) ? 32'd0 : rf[dbg_adr[0]];
    assign dbg_dout[1] = (dbg_adr[1] == 5'd0) ? 32'd0 : rf[dbg_adr[1]];
    assign dbg_dout[2] = (dbg_adr[2] == 5'd0) ? 32'd0 : rf[dbg_adr[2]];

    regfile_dump_reader #(.FIRST_REG(0), .LAST_REG(31), .MSB_FIRST(1'b0)) u0 (
        .clk(clk), .rst(rst), .dump_req(dump_req[0]), .dbg_adr(dbg_adr[0]),
        .dbg_dout(dbg_dout[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .busy(busy[0]), .done(done[0]));
    regfile_dump_reader #(.FIRST_REG(4), .LAST_REG(6), .MSB_FIRST(1'b1)) u1 (
        .clk(clk), .rst(rst), .dump_req(dump_req[1]), .dbg_adr(dbg_adr[1]),
        .dbg_dout(dbg_dout[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .busy(busy[1]), .done(done[1]));
    regfile_dump_reader #(.FIRST_REG(7), .LAST_REG(7), .MSB_FIRST(1'b0)) u2 (
        .clk(clk), .rst(rst), .dump_req(dump_req[2]), .dbg_adr(dbg_adr[2]),
        .dbg_dout(dbg_dout[2]), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
        .tx_ready(tx_ready[2]), .busy(busy[2]), .done(done[2]));

    int n_pass = 0;
    int n_total = 0;

    logic [7:0] got_q [$];
    logic [7:0] exp_q [$];
    int  busy_cyc, ndone, hold_err, extra_err, bp_seen;
    bit  tmo;

    function automatic int fr(input int k);
        return (k == 0) ? 0 : (k == 1) ? 4 : 7;
    endfunction
    function automatic int lr(input int k);
        return (k == 0) ? 31 : (k == 1) ? 6 : 7;
    endfunction
    function automatic bit msb(input int k);
        return k == 1;
    endfunction

    // Expected byte stream from the current regfile contents.
    task automatic model(input int k);
        logic [31:0] w;
        logic [7:0]  v, x;
        int s;
        exp_q = {};
        x = 8'h00;
        for (int r = fr(k); r <= lr(k); r++) begin
            w = (r == 0) ? 32'd0 : rf[r];
            for (int b = 0; b < 4; b++) begin
                s = msb(k) ? 3 - b : b;
                v = 8'((w >> (8 * s)) & 32'hFF);
                exp_q.push_back(v);
                x = x ^ v;
            end
        end
        if (CS == 1) exp_q.push_back(x);
    endtask

    function automatic int diff_count();
        int d = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) d++;
        return d;
    endfunction

    task automatic init_rf();
        for (int r = 0; r < 32; r++) rf[r] = 32'h1122_3300 + 32'(r);
    endtask

    // mode 0: ready tied high, 1: random ready, 2: 5-cycle stall on byte 2 of x5
    task automatic run_dump(input int k, input int mode, input int wb_reg,
                            input logic [31:0] wb_val, input bit mid_req);
        bit   r, prev_v, prev_r, wb_done, mid_done;
        logic [7:0] prev_d;
        int   edges, cnt5;
        got_q = {};
        busy_cyc = 0; ndone = 0; hold_err = 0; extra_err = 0; bp_seen = 0; tmo = 0;
        edges = 0; cnt5 = 0; prev_v = 0; prev_r = 0; prev_d = 0; wb_done = 0; mid_done = 0;
        @(negedge clk);
        dump_req[k] = 1'b1;
        while (1) begin
            @(negedge clk);
            edges++;
            dump_req[k] = 1'b0;
            if (mid_req && !mid_done && busy[k] && tx_valid[k] && dbg_adr[k] == 5'd10) begin
                dump_req[k] = 1'b1;
                mid_done = 1;
            end
            if (busy[k]) busy_cyc++;
            if (done[k]) begin
                ndone++;
                break;
            end
            if (edges > 3000) begin
                tmo = 1;
                break;
            end
            if (prev_v && !prev_r && (!tx_valid[k] || tx_data[k] !== prev_d)) hold_err++;
            if (wb_reg >= 0 && !wb_done && tx_valid[k] && int'(dbg_adr[k]) == wb_reg) begin
                rf[wb_reg] = wb_val;
                wb_done = 1;
            end
            r = 1'b1;
            if (mode == 1) r = ($urandom_range(0, 3) != 0);
            if (mode == 2 && bp_seen < 5 && tx_valid[k] && dbg_adr[k] == 5'd5 && cnt5 == 2) begin
                r = 1'b0;
                bp_seen++;
                if (tx_data[k] !== 8'hBE) hold_err++;
            end
            tx_ready[k] = r;
            if (tx_valid[k] && r) begin
                got_q.push_back(tx_data[k]);
                if (dbg_adr[k] == 5'd5) cnt5++;
            end
            prev_v = tx_valid[k];
            prev_r = r;
            prev_d = tx_data[k];
        end
        dump_req[k] = 1'b0;
        tx_ready[k] = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done[k] || busy[k]) extra_err++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            n_total++;
            if (tx_valid[k] !== 1'b0 || busy[k] !== 1'b0 || done[k] !== 1'b0 ||
                tx_data[k] !== 8'h00 || dbg_adr[k] !== 5'(fr(k))) begin
                $display("FAIL reset_state[%0d]: valid=%b busy=%b done=%b data=%h adr=%0d, want 0 0 0 00 %0d",
                         k, tx_valid[k], busy[k], done[k], tx_data[k], dbg_adr[k], fr(k));
            end else n_pass++;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_full_dump();
        init_rf();
        model(0);
        run_dump(0, 0, -1, 32'd0, 1'b0);
        n_total++;
        if (tmo || got_q.size() != 128 + CS) begin
            $display("FAIL full_count: got %0d bytes (timeout=%0d), want %0d", got_q.size(), tmo, 128 + CS);
        end else n_pass++;
        n_total++;
        if (diff_count() != 0) $display("FAIL full_stream: %0d bytes differ, want 0", diff_count());
        else n_pass++;
        n_total++;
        if (got_q.size() < 8 || got_q[4] !== 8'h01 || got_q[5] !== 8'h33 || got_q[7] !== 8'h11)
            $display("FAIL full_x1_bytes: got %p, want 01 33 22 11 at 4..7", got_q[4:7]);
        else n_pass++;
        n_total++;
        if (busy_cyc != 161 + 2 * CS) $display("FAIL full_cycles: got %0d, want %0d", busy_cyc, 161 + 2 * CS);
        else n_pass++;
        n_total++;
        if (ndone != 1 || extra_err != 0)
            $display("FAIL full_done: done=%0d after_errs=%0d, want 1 0", ndone, extra_err);
        else n_pass++;
    endtask

    task automatic test_random_ready();
        for (int it = 0; it < 2; it++) begin
            for (int r = 0; r < 32; r++) rf[r] = $urandom;
            model(0);
            run_dump(0, 1, -1, 32'd0, 1'b0);
            n_total++;
            if (tmo || got_q.size() != exp_q.size() || diff_count() != 0 || ndone != 1)
                $display("FAIL random_stream[%0d]: got %0d bytes %0d diffs done=%0d, want %0d 0 1",
                         it, got_q.size(), diff_count(), ndone, exp_q.size());
            else n_pass++;
            n_total++;
            if (hold_err != 0) $display("FAIL random_hold[%0d]: %0d unstable stalls, want 0", it, hold_err);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        init_rf();
        rf[5] = 32'hDEAD_BEEF;
        model(1);
        run_dump(1, 2, -1, 32'd0, 1'b0);
        n_total++;
        if (got_q.size() < 8 || got_q[4] !== 8'hDE || got_q[5] !== 8'hAD ||
            got_q[6] !== 8'hBE || got_q[7] !== 8'hEF)
            $display("FAIL bp_x5_bytes: got %p, want DE AD BE EF", got_q);
        else n_pass++;
        n_total++;
        if (bp_seen != 5 || hold_err != 0)
            $display("FAIL bp_hold: stalls=%0d errs=%0d, want 5 0", bp_seen, hold_err);
        else n_pass++;
        n_total++;
        if (tmo || got_q.size() != exp_q.size() || diff_count() != 0 || busy_cyc != 21 + 2 * CS)
            $display("FAIL bp_stream: bytes=%0d diffs=%0d cycles=%0d, want %0d 0 %0d",
                     got_q.size(), diff_count(), busy_cyc, exp_q.size(), 21 + 2 * CS);
        else n_pass++;
    endtask

    task automatic test_single_reg();
        rf[7] = 32'hA5A5_0F0F;
        model(2);
        run_dump(2, 0, -1, 32'd0, 1'b0);
        n_total++;
        if (got_q.size() != 4 + CS || got_q[0] !== 8'h0F || got_q[1] !== 8'h0F ||
            got_q[2] !== 8'hA5 || got_q[3] !== 8'hA5 || diff_count() != 0)
            $display("FAIL single_stream: got %p, want 0F 0F A5 A5", got_q);
        else n_pass++;
        n_total++;
        if (busy_cyc != 6 + 2 * CS || ndone != 1)
            $display("FAIL single_busy: busy=%0d done=%0d, want %0d 1", busy_cyc, ndone, 6 + 2 * CS);
        else n_pass++;
    endtask

    task automatic test_mid_req();
        init_rf();
        model(0);
        run_dump(0, 0, -1, 32'd0, 1'b1);
        n_total++;
        if (ndone != 1 || extra_err != 0 || got_q.size() != 128 + CS || diff_count() != 0)
            $display("FAIL mid_req: done=%0d after_errs=%0d bytes=%0d, want 1 0 %0d",
                     ndone, extra_err, got_q.size(), 128 + CS);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int cnt12 = 0;
        int guard = 0;
        bit hit = 0;
        init_rf();
        @(negedge clk);
        dump_req[0] = 1'b1;
        tx_ready[0] = 1'b1;
        while (guard < 1000) begin
            @(negedge clk);
            guard++;
            dump_req[0] = 1'b0;
            if (tx_valid[0] && dbg_adr[0] == 5'd12 && cnt12 == 1) begin
                hit = 1;
                break;
            end
            if (tx_valid[0] && dbg_adr[0] == 5'd12) cnt12++;
        end
        tx_ready[0] = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_total++;
        if (!hit || tx_valid[0] !== 1'b0 || busy[0] !== 1'b0 || dbg_adr[0] !== 5'd0 || done[0] !== 1'b0)
            $display("FAIL reset_mid: reached=%0d valid=%b busy=%b adr=%0d done=%b, want 1 0 0 0 0",
                     hit, tx_valid[0], busy[0], dbg_adr[0], done[0]);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        model(0);
        run_dump(0, 0, -1, 32'd0, 1'b0);
        n_total++;
        if (tmo || got_q.size() != 128 + CS || diff_count() != 0 || ndone != 1)
            $display("FAIL reset_restart: bytes=%0d diffs=%0d done=%0d, want %0d 0 1",
                     got_q.size(), diff_count(), ndone, 128 + CS);
        else n_pass++;
    endtask

    task automatic test_writeback();
        init_rf();
        model(0);
        run_dump(0, 0, 3, 32'hCAFE_BABE, 1'b0);
        n_total++;
        if (got_q.size() < 16 || got_q[12] !== 8'h03 || got_q[15] !== 8'h11 || diff_count() != 0)
            $display("FAIL wb_old: x3 got %p, want 03 33 22 11", got_q[12:15]);
        else n_pass++;
        model(0);
        run_dump(0, 0, -1, 32'd0, 1'b0);
        n_total++;
        if (got_q.size() < 16 || got_q[12] !== 8'hBE || got_q[13] !== 8'hBA ||
            got_q[14] !== 8'hFE || got_q[15] !== 8'hCA || diff_count() != 0)
            $display("FAIL wb_new: x3 got %p, want BE BA FE CA", got_q[12:15]);
        else n_pass++;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            dump_req[k] = 1'b0;
            tx_ready[k] = 1'b0;
        end
        init_rf();
        rst = 1'b1;
        test_reset();
        test_full_dump();
        test_random_ready();
        test_backpressure();
        test_single_reg();
        test_mid_req();
        test_reset_mid();
        test_writeback();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
